multi_channel_accumulator: RTL and testbench
============================================

// Module: multi_channel_accumulator
// PURPOSE
//   Parametrised successor to the 1-bit NAND preset/accumulator cell: NUM_CH independent WIDTH-bit
//   accumulators, each with its own "primed" flag so the first op after reset/clear loads in_d.
//   Selectable ALU op per transaction. Datapath core of the next microprocessor iteration;
//   fed by the instruction decoder, read back by the output/debug path.
// PARAMETERS
//   WIDTH   8  accumulator and operand width in bits (>=1)
//   NUM_CH  4  number of independent accumulators (>=1, need not be a power of two)
//   CH_W    2  channel-select width; must satisfy 2**CH_W >= NUM_CH
// PORTS
//   clk        in   1       single clock, rising-edge
//   preset_n   in   1       asynchronous, active-low reset
//   in_valid   in   1       transaction strobe; block is always ready (no back-pressure)
//   in_op      in   3       opcode (see BEHAVIOUR)
//   in_ch      in   CH_W    target accumulator
//   in_d       in   WIDTH   operand
//   out_valid  out  1       1-cycle pulse: result of the previous accepted transaction
//   out_ch     out  CH_W    channel that out_acc belongs to
//   out_acc    out  WIDTH   new value of that accumulator
//   out_zero   out  1       out_acc == 0
//   out_carry  out  1       carry/borrow of ADD/SUB (see CONFIGURATION)
//   rd_ch      in   CH_W    asynchronous read select
//   rd_acc     out  WIDTH   combinational view of acc[rd_ch]; 0 if rd_ch >= NUM_CH
// BEHAVIOUR
// - Reset (preset_n=0, async): all acc = 0, all primed = 1, out_valid/out_ch/out_acc/out_carry = 0,
//   out_zero = 1. Takes effect immediately, mid-transaction included; the in-flight op is lost.
// - Accept: in_valid=1 at a rising edge with in_ch < NUM_CH. in_ch >= NUM_CH: ignored, no state
//   change, out_valid=0 next cycle. in_valid=0: all state holds, out_valid=0, out_* hold value.
// - Latency 1: accumulator and out_* update on the same edge; out_valid high for exactly 1 cycle.
// - Opcodes (A = acc[in_ch], D = in_d):
//   000 NAND ~(A&D) | 001 AND A&D | 010 OR A|D | 011 XOR A^D
//   100 ADD A+D mod 2**WIDTH | 101 SUB A-D mod 2**WIDTH | 110 LOAD D
//   111 CLEAR: A=0, primed=1, out_acc=0, out_carry=0
// - Prime rule: if primed[in_ch]=1 and op != CLEAR, A := D regardless of op, primed := 0,
//   out_carry := 0. Mirrors the legacy preset-then-NAND cell when op=NAND.
// - Channels fully independent; an op on one channel never changes another's acc or primed flag.
// - Back-to-back ops on the same channel every cycle use the value written on the prior edge.
// - out_carry: ADD = carry-out of bit WIDTH-1; SUB = borrow (1 iff A < D unsigned);
//   logic ops/LOAD/prime = 0. out_zero derives from the registered out_acc.
// - Internal per-channel state: IDLE_PRIMED -> (any non-CLEAR op) -> ACTIVE; ACTIVE -> (CLEAR) ->
//   IDLE_PRIMED; any state -> (preset_n=0) -> IDLE_PRIMED.
// CONFIGURATION
//   ACC_ARITH_EN defined: ADD/SUB implemented as above, out_carry live.
//   ACC_ARITH_EN undefined: no adder built; ADD/SUB on an ACTIVE channel leave A unchanged (NOP),
//   out_valid still pulses with current A; prime rule still applies; out_carry tied 0.
// TESTING (WIDTH=8, NUM_CH=3, CH_W=2)
// 1. Release reset; NAND ch0 D=A5 -> out_acc=A5 (prime); NAND ch0 D=FF -> out_acc=5A, out_zero=0.
// 2. Then XOR ch1 D=0F -> out_acc=0F, out_ch=1; rd_ch=0 -> rd_acc=5A (ch0 untouched).
// 3. LOAD ch2 F0; ADD ch2 D=20 -> out_acc=10, out_carry=1; SUB ch2 D=11 -> FF, carry=1;
//    without ACC_ARITH_EN: ADD -> out_acc=F0, out_carry=0.
// 4. CLEAR ch0 -> out_acc=00, out_zero=1; AND ch0 D=33 -> out_acc=33 (re-primed, not 00).
// 5. in_valid=1 with in_ch=3 -> out_valid=0, all accs unchanged; in_valid=0 -> out_valid=0.
// 6. Assert preset_n mid-stream between edges -> out_*, rd_acc = 0 at once; after release
//    OR ch1 D=C3 -> out_acc=C3 (prime load).

Source files
------------

// File: rtl/multi_channel_accumulator.sv
// rtl/multi_channel_accumulator.sv - NUM_CH independent WIDTH-bit accumulators with per-op ALU and prime-on-first-use
//
// Purpose:
//   Each channel holds an accumulator and a two-state FSM (IDLE_PRIMED / ACTIVE).
//   The first non-CLEAR op on a primed channel loads in_d. Later ops apply the
//   selected ALU function. Results are registered with a one-cycle latency.
//
// Optional feature macro: ACC_ARITH_EN
//   When it is defined, ADD/SUB are built and out_carry is live.
//   When it is undefined, ADD/SUB on an ACTIVE channel are NOPs and out_carry is 0.
//
// Ports:
//   clk       - rising-edge clock
//   preset_n  - asynchronous active-low reset
//   in_valid  - transaction strobe (always accepted, no back-pressure)
//   in_op     - opcode: NAND AND OR XOR ADD SUB LOAD CLEAR (0..7)
//   in_ch     - target channel; values >= NUM_CH are ignored
//   in_d      - operand
//   out_valid - one-cycle pulse carrying the result of the last accepted op
//   out_ch    - channel of out_acc
//   out_acc   - new accumulator value
//   out_zero  - out_acc == 0
//   out_carry - ADD carry-out / SUB borrow
//   rd_ch     - combinational read select
//   rd_acc    - acc[rd_ch], or 0 when rd_ch >= NUM_CH
module multi_channel_accumulator #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic             clk,
  input  logic             preset_n,
  input  logic             in_valid,
  input  logic [2:0]       in_op,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [WIDTH-1:0] in_d,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic [WIDTH-1:0] out_acc,
  output logic             out_zero,
  output logic             out_carry,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [WIDTH-1:0] rd_acc
);

  typedef enum logic {
    IDLE_PRIMED = 1'b0,
    ACTIVE      = 1'b1
  } ch_state_e;

  localparam logic [2:0] OP_NAND  = 3'd0;
  localparam logic [2:0] OP_AND   = 3'd1;
  localparam logic [2:0] OP_OR    = 3'd2;
  localparam logic [2:0] OP_XOR   = 3'd3;
  localparam logic [2:0] OP_ADD   = 3'd4;
  localparam logic [2:0] OP_SUB   = 3'd5;
  localparam logic [2:0] OP_LOAD  = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  logic [WIDTH-1:0] acc_q   [NUM_CH];
  logic [WIDTH-1:0] acc_d   [NUM_CH];
  ch_state_e        state_q [NUM_CH];
  ch_state_e        state_d [NUM_CH];

  logic             out_valid_q, out_valid_d;
  logic [CH_W-1:0]  out_ch_q,    out_ch_d;
  logic [WIDTH-1:0] out_acc_q,   out_acc_d;
  logic             out_carry_q, out_carry_d;

  logic             accept;
  logic [WIDTH-1:0] cur_a;
  logic             cur_primed;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  ch_state_e        next_state;

  // Channel numbers beyond NUM_CH fall in the CH_W range but have no storage.
  assign accept = in_valid && ({1'b0, in_ch} < NUM_CH_L);

  // The select mux uses a loop so that in_ch >= NUM_CH never indexes past the array.
  always_comb begin
    cur_a      = '0;
    cur_primed = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_ch == CH_W'(i)) begin
        cur_a      = acc_q[i];
        cur_primed = (state_q[i] == IDLE_PRIMED);
      end
    end
  end

  always_comb begin
    alu_res   = cur_a;
    alu_carry = 1'b0;
    case (in_op)
      OP_NAND:  alu_res = ~(cur_a & in_d);
      OP_AND:   alu_res = cur_a & in_d;
      OP_OR:    alu_res = cur_a | in_d;
      OP_XOR:   alu_res = cur_a ^ in_d;
`ifdef ACC_ARITH_EN
      OP_ADD:   {alu_carry, alu_res} = {1'b0, cur_a} + {1'b0, in_d};
      // A wrap-around below zero sets the extra top bit, which is the borrow.
      OP_SUB:   {alu_carry, alu_res} = {1'b0, cur_a} - {1'b0, in_d};
`else
      OP_ADD:   alu_res = cur_a;
      OP_SUB:   alu_res = cur_a;
`endif
      OP_LOAD:  alu_res = in_d;
      OP_CLEAR: alu_res = '0;
      default:  alu_res = cur_a;
    endcase
  end

  // Per-channel FSM next state plus the result that is written back.
  always_comb begin
    next_state  = ACTIVE;
    out_acc_d   = alu_res;
    out_carry_d = alu_carry;
    if (in_op == OP_CLEAR) begin
      next_state  = IDLE_PRIMED;
      out_acc_d   = '0;
      out_carry_d = 1'b0;
    end else if (cur_primed) begin
      out_acc_d   = in_d;
      out_carry_d = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      acc_d[i]   = acc_q[i];
      state_d[i] = state_q[i];
    end
    out_valid_d = accept;
    out_ch_d    = out_ch_q;
    if (accept) begin
      out_ch_d = in_ch;
      for (int i = 0; i < NUM_CH; i++) begin
        if (in_ch == CH_W'(i)) begin
          acc_d[i]   = out_acc_d;
          state_d[i] = next_state;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i]   <= '0;
        state_q[i] <= IDLE_PRIMED;
      end
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_acc_q   <= '0;
      out_carry_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i]   <= acc_d[i];
        state_q[i] <= state_d[i];
      end
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      if (accept) begin
        out_acc_q   <= out_acc_d;
        out_carry_q <= out_carry_d;
      end
    end
  end

  always_comb begin
    rd_acc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) rd_acc = acc_q[i];
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_acc   = out_acc_q;
  assign out_zero  = (out_acc_q == '0);
  assign out_carry = out_carry_q;

endmodule

// File: tb/tb_multi_channel_accumulator.sv
// tb/tb_multi_channel_accumulator.sv - self-checking bench for multi_channel_accumulator
module tb_multi_channel_accumulator;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 3;
  localparam int CH_W   = 2;

  logic             clk = 1'b0;
  logic             preset_n;
  logic             in_valid;
  logic [2:0]       in_op;
  logic [CH_W-1:0]  in_ch;
  logic [WIDTH-1:0] in_d;
  logic             out_valid;
  logic [CH_W-1:0]  out_ch;
  logic [WIDTH-1:0] out_acc;
  logic             out_zero;
  logic             out_carry;
  logic [CH_W-1:0]  rd_ch;
  logic [WIDTH-1:0] rd_acc;

  int errors = 0;
  int checks = 0;

  multi_channel_accumulator #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk(clk), .preset_n(preset_n), .in_valid(in_valid), .in_op(in_op),
    .in_ch(in_ch), .in_d(in_d), .out_valid(out_valid), .out_ch(out_ch),
    .out_acc(out_acc), .out_zero(out_zero), .out_carry(out_carry),
    .rd_ch(rd_ch), .rd_acc(rd_acc)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_acc    [NUM_CH];
  bit m_primed [NUM_CH];
  bit e_valid;
  int e_ch, e_acc;
  bit e_carry;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_acc[i] = 0;
      m_primed[i] = 1;
    end
    e_valid = 0; e_ch = 0; e_acc = 0; e_carry = 0;
  endtask

  task automatic model_step(input bit v, input int op, input int ch, input int d);
    int a, r;
    bit c;
    if (!v || ch >= NUM_CH) begin
      e_valid = 0;
      return;
    end
    a = m_acc[ch];
    r = a;
    c = 0;
    if (op == 7) begin
      r = 0;
      m_primed[ch] = 1;
    end else if (m_primed[ch]) begin
      r = d;
      m_primed[ch] = 0;
    end else begin
      case (op)
        0: r = 255 - (a & d);
        1: r = a & d;
        2: r = a | d;
        3: r = a ^ d;
`ifdef ACC_ARITH_EN
        4: begin r = (a + d) % 256; c = (a + d) > 255; end
        5: begin r = (a - d + 256) % 256; c = a < d; end
`endif
        6: r = d;
        default: r = a;
      endcase
    end
    m_acc[ch] = r;
    e_valid = 1; e_ch = ch; e_acc = r; e_carry = c;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".valid"}, int'(out_valid), int'(e_valid));
    check({tag, ".ch"},    int'(out_ch),    e_ch);
    check({tag, ".acc"},   int'(out_acc),   e_acc);
    check({tag, ".zero"},  int'(out_zero),  int'(e_acc == 0));
    check({tag, ".carry"}, int'(out_carry), int'(e_carry));
  endtask

  // Inputs are driven on the falling edge and outputs are sampled on the next falling edge.
  task automatic do_op(input bit v, input int op, input int ch, input int d);
    in_valid = v; in_op = 3'(op); in_ch = CH_W'(ch); in_d = WIDTH'(d);
    @(posedge clk);
    model_step(v, op, ch, d);
    @(negedge clk);
    in_valid = 0;
  endtask

  typedef struct {
    bit v; int op; int ch; int d;
    bit ev; int ech; int eacc; bit ecarry;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1, 0, 0, 'hA5, 1, 0, 'hA5, 0};
    vecs[1] = '{1, 0, 0, 'hFF, 1, 0, 'h5A, 0};
    vecs[2] = '{1, 3, 1, 'h0F, 1, 1, 'h0F, 0};
    vecs[3] = '{1, 6, 2, 'hF0, 1, 2, 'hF0, 0};
`ifdef ACC_ARITH_EN
    vecs[4] = '{1, 4, 2, 'h20, 1, 2, 'h10, 1};
    vecs[5] = '{1, 5, 2, 'h11, 1, 2, 'hFF, 1};
`else
    vecs[4] = '{1, 4, 2, 'h20, 1, 2, 'hF0, 0};
    vecs[5] = '{1, 5, 2, 'h11, 1, 2, 'hF0, 0};
`endif
    vecs[6] = '{1, 7, 0, 'hAA, 1, 0, 'h00, 0};
    vecs[7] = '{1, 1, 0, 'h33, 1, 0, 'h33, 0};
    vecs[8] = '{1, 0, 3, 'h77, 0, 0, 'h33, 0};
    vecs[9] = '{0, 2, 1, 'h44, 0, 0, 'h33, 0};

    preset_n = 0; in_valid = 0; in_op = 0; in_ch = 0; in_d = 0; rd_ch = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outs("reset");
    check("reset.rd_acc", int'(rd_acc), 0);
    preset_n = 1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].v, vecs[i].op, vecs[i].ch, vecs[i].d);
      check($sformatf("vec%0d.valid", i), int'(out_valid), int'(vecs[i].ev));
      check($sformatf("vec%0d.ch", i),    int'(out_ch),    vecs[i].ech);
      check($sformatf("vec%0d.acc", i),   int'(out_acc),   vecs[i].eacc);
      check($sformatf("vec%0d.zero", i),  int'(out_zero),  int'(vecs[i].eacc == 0));
      check($sformatf("vec%0d.carry", i), int'(out_carry), int'(vecs[i].ecarry));
      if (i == 2) begin
        rd_ch = 0; #1;
        check("iso.rd_ch0", int'(rd_acc), 'h5A);
      end
    end

    for (int c = 0; c < 4; c++) begin
      rd_ch = CH_W'(c); #1;
      check($sformatf("tbl.rd_ch%0d", c), int'(rd_acc), (c < NUM_CH) ? m_acc[c] : 0);
    end

    // Reset lands between edges while a transaction is being driven; it must be lost.
    in_valid = 1; in_op = 3'd2; in_ch = 0; in_d = 8'h11;
    #2 preset_n = 0;
    model_reset();
    rd_ch = 2;
    #1;
    check_outs("midrst");
    check("midrst.rd_acc", int'(rd_acc), 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    preset_n = 1;
    check_outs("rst_hold");
    rd_ch = 0; #1;
    check("rst_hold.rd_ch0", int'(rd_acc), 0);
    do_op(1, 2, 1, 'hC3);
    check("post_rst.acc", int'(out_acc), 'hC3);
    check_outs("post_rst");

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      int op, ch, d;
      bit v;
      v  = ($urandom % 4) != 0;
      op = $urandom % 8;
      if (op == 7 && ($urandom % 2)) op = $urandom % 7;
      ch = $urandom % 4;
      d  = $urandom % 256;
      do_op(v, op, ch, d);
      check_outs($sformatf("rnd%0d", n));
      rd_ch = CH_W'($urandom % 4); #1;
      check($sformatf("rnd%0d.rd", n), int'(rd_acc),
            (int'(rd_ch) < NUM_CH) ? m_acc[int'(rd_ch)] : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
